// File: rtl/text_console_pkg.sv
// Purpose: shared constants, control codes and state types for the text console writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_console_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 13;

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_CR,
    CUR_BACK,
    CUR_HOME
  } cursor_op_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_cursor_tracker.sv
// Purpose: row/col cursor with advance, newline, CR, backspace and home; emits row*COLS+col.
// Latency: one cycle from op to updated addr (registered).
// Backpressure: none; accepts one op every cycle.
module text_cursor_tracker
  import text_console_pkg::*;
#(
  parameter int COLS = text_console_pkg::COLS,
  parameter int ROWS = text_console_pkg::ROWS
) (
  input  logic              clk,
  input  logic              reset,
  input  cursor_op_e        op,
  output logic [ADDR_W-1:0] addr
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_inc, row_dec;

  // Row neighbours with page wrap; there is no scrolling, the page is a torus.
  assign row_inc = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
  assign row_dec = (row_q == '0) ? ROW_MAX : row_q - ROW_W'(1);

  // Apply the requested cursor operation and precompute the linear address.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    case (op)
      CUR_ADVANCE: begin
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      CUR_NEWLINE: begin
        col_d = '0;
        row_d = row_inc;
      end
      CUR_CR: begin
        col_d = '0;
      end
      CUR_BACK: begin
        if (col_q == '0) begin
          col_d = COL_MAX;
          row_d = row_dec;
        end else begin
          col_d = col_q - COL_W'(1);
        end
      end
      CUR_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      default: ;
    endcase
    addr_d = ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d);
  end

  // Cursor state register; the linear address is kept registered alongside row/col.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/text_console_writer.sv
// Purpose: ASCII stream to 80x60 text page writer with LF/CR/BS/FF handling; optional page clear under TEXT_WRITER_CLEAR_EN.
// Latency: printable byte written one cycle after acceptance when disp is low; ready again two cycles after acceptance.
// Backpressure: char_ready only in IDLE; memory writes stall (no skip) while disp is high.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int         COLS       = text_console_pkg::COLS,
  parameter int         ROWS       = text_console_pkg::ROWS,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              disp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

`ifdef TEXT_WRITER_CLEAR_EN
  localparam int     CELL_CNT    = COLS * ROWS;
  localparam state_e RESET_STATE = ST_CLEAR;
  logic [ADDR_W-1:0] clr_q, clr_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  cursor_op_e        cur_op;
  logic              accept;

  assign char_ready = (state_q == ST_IDLE) && !reset;
  assign accept     = char_valid && char_ready;
  assign busy       = (state_q != ST_IDLE);

  text_cursor_tracker #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk   (CLOCK_50),
    .reset (reset),
    .op    (cur_op),
    .addr  (cursor_addr)
  );

  // Next-state, cursor op and write-port decisions. The write decision is taken
  // from disp one cycle early so that mem_we/mem_addr/mem_data leave flops.
  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cur_op     = CUR_NONE;
`ifdef TEXT_WRITER_CLEAR_EN
    clr_d      = clr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(char_data)) begin
            state_d    = ST_WRITE;
            mem_addr_d = cursor_addr;
            mem_data_d = char_data;
            mem_we_d   = !disp;
            cur_op     = CUR_ADVANCE;
          end else begin
            case (char_data)
              CH_LF: cur_op = CUR_NEWLINE;
              CH_CR: cur_op = CUR_CR;
              CH_BS: begin
                // Linear decrement matches the col-0 -> previous-row wrap.
                if (cursor_addr != '0) begin
                  state_d    = ST_WRITE;
                  mem_addr_d = cursor_addr - ADDR_W'(1);
                  mem_data_d = BLANK_CHAR;
                  mem_we_d   = !disp;
                  cur_op     = CUR_BACK;
                end
              end
              CH_FF: begin
`ifdef TEXT_WRITER_CLEAR_EN
                state_d = ST_CLEAR;
                clr_d   = '0;
`endif
                cur_op  = CUR_HOME;
              end
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        // mem_we_q high means the single pulse is already out.
        if (mem_we_q) begin
          state_d = ST_IDLE;
        end else if (!disp) begin
          mem_we_d = 1'b1;
        end
      end
`ifdef TEXT_WRITER_CLEAR_EN
      ST_CLEAR: begin
        if (!disp) begin
          mem_we_d   = 1'b1;
          mem_addr_d = clr_q;
          mem_data_d = BLANK_CHAR;
          if (clr_q == ADDR_W'(CELL_CNT - 1)) begin
            state_d = ST_IDLE;
            cur_op  = CUR_HOME;
          end else begin
            clr_d = clr_q + ADDR_W'(1);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered write port; reset aborts any pending write.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= BLANK_CHAR;
`ifdef TEXT_WRITER_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef TEXT_WRITER_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

endmodule
